reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL be a 32-entry x 32-bit register file with two read ports and one write port, using one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  sole clock; all register updates occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; clears the whole array.
REQ-004 readReg1Addr  input  5  index of the register driven onto reg1Data.
REQ-005 readReg2Addr  input  5  index of the register driven onto reg2Data.
REQ-006 writeRegAddr  input  5  index of the register written when regWrite=1.
REQ-007 regWrite  input  1  write enable, active high.
REQ-008 writeData  input  32  data written to writeRegAddr.
REQ-009 reg1Data  output  32  contents of register readReg1Addr.
REQ-010 reg2Data  output  32  contents of register readReg2Addr.
REQ-011 Port order SHALL be clk, rst_n, readReg1Addr, readReg2Addr, writeRegAddr, regWrite, writeData, reg1Data, reg2Data.
REQ-012 The block SHALL have no parameters; width 32 and depth 32 are fixed.

Function
REQ-013 Reads SHALL be combinational: reg1Data/reg2Data follow address or stored-content changes with no clock latency.
REQ-014 Both read ports SHALL be independent; both may address the same register, including the one being written.
REQ-015 On a rising clk edge with rst_n=1 and regWrite=1, writeData SHALL be stored into register writeRegAddr.
REQ-016 With regWrite=0, no register SHALL change, whatever writeRegAddr/writeData are.
REQ-017 Register 0 SHALL read as 0 at all times; writes to address 0 SHALL be discarded.
REQ-018 No write-to-read bypass: a read of the register being written SHALL return the old value until the writing edge, then the new value.
REQ-019 Repeated writes to one register SHALL leave the last written value; other registers SHALL be unaffected.
REQ-020 All 32 bits SHALL be stored and returned unmodified; no sign extension or truncation.
REQ-021 Unknown or X read addresses SHALL NOT corrupt stored contents.

Reset
REQ-022 rst_n=0 SHALL clear registers 0-31 to 0 immediately, without waiting for clk.
REQ-023 While rst_n=0, writes SHALL be blocked and both outputs SHALL read 0 for every address.
REQ-024 A reset asserted mid-sequence SHALL clear all previously written values.
REQ-025 After rst_n rises, the first write SHALL take effect on the next rising clk edge that has regWrite=1.

Verification
REQ-026 Reset, then read addresses 0-31 on both ports -> every read returns 0.
REQ-027 With regWrite=1, write r1=13, r5=47, r2=47, r3=4, r4=56, r5=42, r6=7. Then drop regWrite and present r7=84 and r5=74. Read pairs (1,2), (2,3), (3,4), (4,5), (5,6), (6,7) -> 13/47, 47/4, 4/56, 56/42, 42/7, 7/0.
REQ-028 Write 0xFFFFFFFF to r0, then read r0 on both ports -> 0.
REQ-029 Set readReg1Addr=9 and write r9=0xDEADBEEF: before the edge reg1Data holds the old value (0); after the edge it reads 0xDEADBEEF.
REQ-030 Write r10=0x12345678, then assert rst_n=0 between clock edges -> reg1Data at address 10 drops to 0 with no clk edge.
REQ-031 Point both read ports at r31 after writing r31=0x80000001 -> both ports read 0x80000001.

Source files
------------

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : 32-entry x 32-bit register file. It has two combinational read
//            ports and one synchronous write port. Register 0 always reads
//            as zero. An asynchronous active-low reset clears every entry.
// Ports    : clk          - sole clock; writes happen on its rising edge
//            rst_n        - asynchronous active-low reset, clears the array
//            readReg1Addr - index driven onto reg1Data
//            readReg2Addr - index driven onto reg2Data
//            writeRegAddr - index written when regWrite=1
//            regWrite     - write enable, active high
//            writeData    - data stored at writeRegAddr
//            reg1Data     - contents of register readReg1Addr
//            reg2Data     - contents of register readReg2Addr
// Revision : 1.0 - initial release
// ============================================================================
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  readReg1Addr,
    input  logic [4:0]  readReg2Addr,
    input  logic [4:0]  writeRegAddr,
    input  logic        regWrite,
    input  logic [31:0] writeData,
    output logic [31:0] reg1Data,
    output logic [31:0] reg2Data
);

    localparam int c_DEPTH = 32;

    logic [31:0] regs_q [c_DEPTH];
    logic [31:0] regs_d [c_DEPTH];

    // Next-state array. Entry 0 is pinned to zero so that a write to
    // address 0 is dropped rather than stored.
    always_comb begin
        regs_d = regs_q;
        if (regWrite && (writeRegAddr != 5'd0)) begin
            regs_d[writeRegAddr] = writeData;
        end
        regs_d[0] = 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // The read ports come straight from the stored array, with no bypass
    // from the write port. A read of the register being written shows the
    // old value until the writing edge. The explicit zero for address 0
    // keeps the read path independent of entry 0's flops.
    assign reg1Data = (readReg1Addr == 5'd0) ? 32'd0 : regs_q[readReg1Addr];
    assign reg2Data = (readReg2Addr == 5'd0) ? 32'd0 : regs_q[readReg2Addr];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Self-checking bench for reg_file. A plain array model holds the
//            expected register contents. A compare process checks both read
//            ports against the model on every falling clock edge. Directed
//            literal checks pin the model to known values. A randomized phase
//            then mixes writes, reads, address-0 writes and mid-run resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  readReg1Addr;
    logic [4:0]  readReg2Addr;
    logic [4:0]  writeRegAddr;
    logic        regWrite;
    logic [31:0] writeData;
    logic [31:0] reg1Data;
    logic [31:0] reg2Data;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    logic [31:0] model [32];

    reg_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .readReg1Addr (readReg1Addr),
        .readReg2Addr (readReg2Addr),
        .writeRegAddr (writeRegAddr),
        .regWrite     (regWrite),
        .writeData    (writeData),
        .reg1Data     (reg1Data),
        .reg2Data     (reg2Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: reset empties the file. An enabled write to a
    // non-zero address stores the data. Everything else leaves it alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'd0;
        end else if (regWrite === 1'b1 && writeRegAddr != 5'd0) begin
            model[writeRegAddr] <= writeData;
        end
    end

    // Continuous comparison of both read ports against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_rd1", reg1Data, model[readReg1Addr]);
            check("cmp_rd2", reg2Data, model[readReg2Addr]);
        end
    end

    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #2;
        regWrite     = w;
        writeRegAddr = wa;
        writeData    = wd;
        readReg1Addr = a1;
        readReg2Addr = a2;
    endtask

    int p1 [6] = '{1, 2, 3, 4, 5, 6};
    int e1 [6] = '{13, 47, 4, 56, 42, 7};
    int e2 [6] = '{47, 4, 56, 42, 7, 0};

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        regWrite     = 1'b0;
        writeRegAddr = 5'd0;
        writeData    = 32'd0;
        readReg1Addr = 5'd0;
        readReg2Addr = 5'd0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;

        // Every address reads zero on both ports while reset is held.
        // A write is also requested; it must be ignored.
        regWrite     = 1'b1;
        writeRegAddr = 5'd3;
        writeData    = 32'hA5A5_A5A5;
        for (int a = 0; a < 32; a++) begin
            readReg1Addr = 5'(a);
            readReg2Addr = 5'(31 - a);
            #1;
            check("reset_rd1", reg1Data, 32'd0);
            check("reset_rd2", reg2Data, 32'd0);
        end
        regWrite = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_cmp = 1'b1;

        // Sequence of writes, then disabled writes that must not land.
        step(1, 5'd1, 32'd13, 0, 0);
        step(1, 5'd5, 32'd47, 0, 0);
        step(1, 5'd2, 32'd47, 0, 0);
        step(1, 5'd3, 32'd4,  0, 0);
        step(1, 5'd4, 32'd56, 0, 0);
        step(1, 5'd5, 32'd42, 0, 0);
        step(1, 5'd6, 32'd7,  0, 0);
        step(0, 5'd7, 32'd84, 0, 0);
        step(0, 5'd5, 32'd74, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 5'd5, 32'd74, 5'(p1[i]), 5'(p1[i] + 1));
            @(negedge clk);
            #1;
            check("seq_rd1", reg1Data, 32'(e1[i]));
            check("seq_rd2", reg2Data, 32'(e2[i]));
        end

        // A write to register 0 is discarded.
        step(1, 5'd0, 32'hFFFF_FFFF, 0, 0);
        step(0, 5'd0, 32'd0, 0, 0);
        @(negedge clk);
        #1;
        check("r0_rd1", reg1Data, 32'd0);
        check("r0_rd2", reg2Data, 32'd0);

        // No bypass: the old value is visible until the writing edge.
        step(0, 5'd0, 32'd0, 5'd9, 5'd9);
        @(posedge clk);
        #2;
        regWrite     = 1'b1;
        writeRegAddr = 5'd9;
        writeData    = 32'hDEAD_BEEF;
        #1;
        check("nobypass_before", reg1Data, 32'd0);
        @(posedge clk);
        #1;
        check("nobypass_after", reg1Data, 32'hDEAD_BEEF);
        #1 regWrite = 1'b0;

        // Full-width value on both ports at the top address.
        step(1, 5'd31, 32'h8000_0001, 5'd31, 5'd31);
        step(0, 5'd0, 32'd0, 5'd31, 5'd31);
        @(negedge clk);
        #1;
        check("r31_rd1", reg1Data, 32'h8000_0001);
        check("r31_rd2", reg2Data, 32'h8000_0001);

        // Asynchronous reset between edges clears the array immediately.
        step(1, 5'd10, 32'h1234_5678, 5'd10, 5'd9);
        step(0, 5'd0, 32'd0, 5'd10, 5'd9);
        @(negedge clk);
        #1;
        check("pre_async_rst", reg1Data, 32'h1234_5678);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_r10", reg1Data, 32'd0);
        check("async_rst_r9", reg2Data, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic: writes, disabled writes, address 0, reads of
        // the address being written, and occasional mid-run resets.
        for (int n = 0; n < 600; n++) begin
            logic        w;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            w  = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wd = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            step(w, wa, wd, a1, a2);
            if (rst_n == 1'b0) rst_n = 1'b1;
            if ($urandom_range(0, 59) == 0) begin
                #1 rst_n = 1'b0;
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_cmp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
